// File: rtl/ctr_pair_pkg.sv
// Shared definitions for the two-requester counter-pair arbiter:
// opcode and FSM encodings plus the values loaded by CLR and reset.
package ctr_pair_pkg;

    typedef enum logic [1:0] {
        OP_INC_X = 2'b00,
        OP_INC_Y = 2'b01,
        OP_SYNC  = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_EXEC  = 2'b10
    } state_e;

    localparam int unsigned CLR_X_VAL = 1;
    localparam int unsigned CLR_Y_VAL = 0;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on contention the requester that did not
// win last time is picked; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/ctr_pair_arbiter.sv
// Arbitrates two requesters onto a shared pair of counters (x, y) through an
// IDLE -> GRANT -> EXEC sequence, keeping y <= x at all times.
module ctr_pair_arbiter
    import ctr_pair_pkg::*;
#(
    parameter int unsigned    W       = 4,
    parameter logic [W-1:0]   CNT_MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    output logic [1:0]   gnt,
    output logic         done,
    output logic         rej,
    output logic         busy,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         prop
);

    state_e       state_q, state_d;
    logic         win_q, win_d;
    op_e          op_q, op_d;
    logic         last_q, last_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;

    logic         pick_win;
    logic         pick_valid;
    logic         exec_rej;

    rr_pick2 u_rr_pick2 (
        .req         (req),
        .last_winner (last_q),
        .winner      (pick_win),
        .valid       (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        op_d     = op_q;
        last_d   = last_q;
        x_d      = x_q;
        y_d      = y_q;
        exec_rej = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    win_d   = pick_win;
                    last_d  = pick_win;
                    op_d    = op_e'(pick_win ? op1 : op0);
                end
            end
            S_GRANT: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_INC_X: begin
                        if (x_q != CNT_MAX) begin
                            x_d = x_q + W'(1);
                        end else begin
                            exec_rej = 1'b1;
                        end
                    end
                    OP_INC_Y: begin
                        if (y_q < x_q) begin
                            y_d = y_q + W'(1);
                        end else begin
                            exec_rej = 1'b1;
                        end
                    end
                    OP_SYNC: begin
                        y_d = x_q;
                    end
                    OP_CLR: begin
                        x_d = W'(CLR_X_VAL);
                        y_d = W'(CLR_Y_VAL);
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            op_q    <= OP_INC_X;
            last_q  <= 1'b1;
            x_q     <= W'(CLR_X_VAL);
            y_q     <= W'(CLR_Y_VAL);
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Pulses are masked while reset is held so an aborted operation never reports completion.
    assign gnt  = (rst_n && (state_q == S_GRANT)) ? onehot2(win_q) : 2'b00;
    assign done = rst_n && (state_q == S_EXEC);
    assign rej  = done && exec_rej;
    assign busy = (state_q != S_IDLE);
    assign x    = x_q;
    assign y    = y_q;
    assign prop = !(y_q > x_q);

    a_prop: assert property (@(posedge clk) disable iff (!rst_n) prop);
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_state: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt != 2'b00) |-> (state_q == S_GRANT));
    a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> (state_q == S_EXEC));

endmodule
